operand_regfile: RTL and testbench
==================================

Name: operand_regfile

Overview:
Register file and flag register that sit directly upstream of the 8-bit ALU in the CPU datapath. Supplies the ALU's A and B operands and carry-in from 16 general registers and a C/Z/N flag register. Captures ALU result and flag outputs on writeback. Also maintains a 16-bit pointer pair with post-increment/decrement, and a shadow flag copy for interrupt entry/return.

Parameters:
NREGS, 16, number of 8-bit registers (power of two; address width = log2(NREGS))
PTR_BASE, 14, index of pointer low byte; pointer = {r[PTR_BASE+1], r[PTR_BASE]}

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
addr_a  in  4  read port A register index
addr_b  in  4  read port B register index
data_a  out  8  operand A to ALU
data_b  out  8  operand B to ALU
wr_en  in  1  register write enable
wr_addr  in  4  write register index
wr_data  in  8  write data (ALU result)
flag_we  in  3  per-flag update enable {C,Z,N}
c_in  in  1  carry from ALU
z_in  in  1  zero from ALU
n_in  in  1  negative from ALU
carry  out  1  registered C flag; drives ALU carry-in
zero  out  1  registered Z flag
neg  out  1  registered N flag
ptr  out  16  current pointer value
ptr_inc  in  1  post-increment pointer
ptr_dec  in  1  post-decrement pointer
irq_enter  in  1  save flags to shadow
irq_return  in  1  restore flags from shadow

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- While rst_n is low, all registers, flags {C,Z,N} and the shadow flags are 0. Therefore data_a = data_b = 0, carry = zero = neg = 0, ptr = 16'h0000.
- Reads are combinational: data_a = r[addr_a], data_b = r[addr_b].
- Write-first bypass: if wr_en and wr_addr == addr_a, then data_a = wr_data in that same cycle. The same rule applies to port B. Both ports may bypass at once.
- Write: on a rising edge with wr_en high, r[wr_addr] <= wr_data. Single write port; writeback latency is one cycle.
- Flags: each flag loads its input only when its flag_we bit is set. flag_we[2] gates C, [1] gates Z, [0] gates N. Flags whose bit is clear hold.
- Flags have no bypass: carry reflects only the value registered before the current edge.
- Pointer output: ptr = {r[PTR_BASE+1], r[PTR_BASE]}, read combinationally with no bypass.
- ptr_inc alone: pointer <= ptr + 1, modulo 2^16. 16'hFFFF wraps to 16'h0000, and the carry propagates into the high byte (16'h00FF -> 16'h0100).
- ptr_dec alone: pointer <= ptr - 1. 16'h0000 wraps to 16'hFFFF.
- ptr_inc and ptr_dec together: no pointer change.
- Write/pointer collision: if wr_en targets PTR_BASE or PTR_BASE+1 in the same cycle as ptr_inc or ptr_dec, the explicit write wins. The inc/dec is suppressed entirely for both bytes, and only the written byte changes.
- irq_enter: shadow <= {C,Z,N} as they stand before the edge. Any simultaneous flag_we update still applies to the live flags.
- irq_return: {C,Z,N} <= shadow, overriding flag_we for that cycle.
- irq_enter and irq_return together: the restore occurs, and the shadow also captures the pre-edge live flags, giving a swap.
- Reset mid-operation: asserting rst_n low clears all state immediately (asynchronously). The first writes are accepted on the first rising edge after rst_n goes high.
- Out-of-range addresses: none exist for NREGS = 16. For smaller NREGS, the upper index bits are ignored (index taken modulo NREGS).

Test Plan:
- Reset then read all addresses -> data_a = data_b = 8'h00, flags 0, ptr 16'h0000. Assert rst_n low mid-write -> all outputs 0 immediately, without waiting for a clock edge.
- Write r3 = 8'hA5 with addr_a = 3 in the same cycle -> data_a = 8'hA5 before the edge (bypass); addr_b = 3 on the next cycle -> data_b = 8'hA5.
- Set r14 = 8'hFF, r15 = 8'h00, pulse ptr_inc -> ptr = 16'h0100. Then ptr_dec twice -> 16'h00FE. Set the pointer to 16'h0000 and ptr_dec -> 16'hFFFF. Assert ptr_inc and ptr_dec together -> no change.
- With ptr = 16'h1234, assert ptr_inc and a write of r14 = 8'h80 in the same cycle -> ptr = 16'h1280 (increment suppressed).
- With flags C=1, Z=0, N=1, apply flag_we = 3'b010 with z_in = 1 and c_in = 0 -> C=1, Z=1, N=1. With carry = 1 in a cycle where c_in = 0 and flag_we[2] = 1, carry stays 1 until the edge.
- With C,Z,N = 1,0,1, pulse irq_enter, then load flags 0,1,0, then pulse irq_return -> flags 1,0,1. Assert both together with live flags 0,1,0 and shadow 1,0,1 -> live flags become 1,0,1 and shadow becomes 0,1,0.

Source files
------------

// File: rtl/operand_regfile.sv
// operand_regfile: general registers and C/Z/N flags feeding the 8-bit ALU.
// Two combinational read ports with write-first bypass, one write port,
// a post-inc/dec pointer held in two adjacent registers, and a shadow
// flag copy for interrupt entry/return.
module operand_regfile #(
  parameter int NREGS    = 16,
  parameter int PTR_BASE = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  addr_a,
  input  logic [3:0]  addr_b,
  output logic [7:0]  data_a,
  output logic [7:0]  data_b,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [2:0]  flag_we,
  input  logic        c_in,
  input  logic        z_in,
  input  logic        n_in,
  output logic        carry,
  output logic        zero,
  output logic        neg,
  output logic [15:0] ptr,
  input  logic        ptr_inc,
  input  logic        ptr_dec,
  input  logic        irq_enter,
  input  logic        irq_return
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [AW-1:0] PTR_LO = AW'(PTR_BASE);
  localparam logic [AW-1:0] PTR_HI = AW'(PTR_BASE + 1);

  // Indices are taken modulo NREGS by dropping the upper address bits.
  logic [AW-1:0] a_idx;
  logic [AW-1:0] b_idx;
  logic [AW-1:0] w_idx;
  assign a_idx = addr_a[AW-1:0];
  assign b_idx = addr_b[AW-1:0];
  assign w_idx = wr_addr[AW-1:0];

  logic [NREGS-1:0][7:0] regs;
  logic [2:0]            flags_reg;   // {C,Z,N}
  logic [2:0]            shadow_reg;  // {C,Z,N} saved on interrupt entry

  // Pointer stepping: an explicit write to either pointer byte suppresses
  // the inc/dec for both bytes; inc and dec together cancel out.
  logic        wr_hits_ptr;
  logic        ptr_step;
  logic [15:0] ptr_next;
  assign wr_hits_ptr = wr_en && ((w_idx == PTR_LO) || (w_idx == PTR_HI));
  assign ptr_step    = (ptr_inc ^ ptr_dec) && !wr_hits_ptr;
  assign ptr_next    = ptr_inc ? (ptr + 16'd1) : (ptr - 16'd1);
  assign ptr         = {regs[PTR_BASE+1], regs[PTR_BASE]};

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [7:0] q_reg;
      logic       step_load;
      logic [7:0] step_byte;

      if (gi == PTR_BASE) begin : g_ptr_lo
        assign step_load = ptr_step;
        assign step_byte = ptr_next[7:0];
      end else if (gi == PTR_BASE + 1) begin : g_ptr_hi
        assign step_load = ptr_step;
        assign step_byte = ptr_next[15:8];
      end else begin : g_plain
        assign step_load = 1'b0;
        assign step_byte = 8'h00;
      end

      // Register storage: explicit write has priority over pointer stepping.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= 8'h00;
        end else if (wr_en && (w_idx == AW'(gi))) begin
          q_reg <= wr_data;
        end else if (step_load) begin
          q_reg <= step_byte;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  // Read ports with write-first bypass; bypass is held off during reset so
  // the operands read as zero while rst_n is low.
  logic byp_a;
  logic byp_b;
  assign byp_a  = rst_n && wr_en && (w_idx == a_idx);
  assign byp_b  = rst_n && wr_en && (w_idx == b_idx);
  assign data_a = byp_a ? wr_data : regs[a_idx];
  assign data_b = byp_b ? wr_data : regs[b_idx];

  // Live flags: restore from shadow wins over per-flag writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= 3'b000;
    end else if (irq_return) begin
      flags_reg <= shadow_reg;
    end else begin
      if (flag_we[2]) flags_reg[2] <= c_in;
      if (flag_we[1]) flags_reg[1] <= z_in;
      if (flag_we[0]) flags_reg[0] <= n_in;
    end
  end

  // Shadow flags capture the pre-edge live flags on interrupt entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= 3'b000;
    end else if (irq_enter) begin
      shadow_reg <= flags_reg;
    end
  end

  assign carry = flags_reg[2];
  assign zero  = flags_reg[1];
  assign neg   = flags_reg[0];

endmodule

// File: tb/tb_operand_regfile.sv
// tb_operand_regfile: scenario tasks with a scoreboard queue of expected
// values for the operand register file.
module tb_operand_regfile;

  logic        clk;
  logic        rst_n;
  logic [3:0]  addr_a;
  logic [3:0]  addr_b;
  logic [7:0]  data_a;
  logic [7:0]  data_b;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  flag_we;
  logic        c_in;
  logic        z_in;
  logic        n_in;
  logic        carry;
  logic        zero;
  logic        neg;
  logic [15:0] ptr;
  logic        ptr_inc;
  logic        ptr_dec;
  logic        irq_enter;
  logic        irq_return;

  operand_regfile #(.NREGS(16), .PTR_BASE(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we), .c_in(c_in), .z_in(z_in), .n_in(n_in),
    .carry(carry), .zero(zero), .neg(neg),
    .ptr(ptr), .ptr_inc(ptr_inc), .ptr_dec(ptr_dec),
    .irq_enter(irq_enter), .irq_return(irq_return)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_v;
  logic [7:0]  model [16];

  task automatic idle();
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
    flag_we = 3'b000; c_in = 1'b0; z_in = 1'b0; n_in = 1'b0;
    ptr_inc = 1'b0; ptr_dec = 1'b0; irq_enter = 1'b0; irq_return = 1'b0;
  endtask

  // Advance one clock; the register model follows accepted writes.
  task automatic step();
    @(posedge clk);
    if (rst_n && wr_en) model[wr_addr] = wr_data;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i); addr_b = 4'(15 - i);
      sb.push_back(16'h0000); sb.push_back(16'h0000);
      #1;
      exp_v = sb.pop_front(); n_cmp++;
      if ({8'h00, data_a} !== exp_v) begin n_fail++; $display("FAIL reset_data_a[%0d]: got %h expected %h", i, data_a, exp_v); end
      exp_v = sb.pop_front(); n_cmp++;
      if ({8'h00, data_b} !== exp_v) begin n_fail++; $display("FAIL reset_data_b[%0d]: got %h expected %h", 15 - i, data_b, exp_v); end
    end
    sb.push_back(16'h0000); sb.push_back(16'h0000);
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({13'h0, carry, zero, neg} !== exp_v) begin n_fail++; $display("FAIL reset_flags: got %b%b%b expected %h", carry, zero, neg, exp_v); end
    exp_v = sb.pop_front(); n_cmp++;
    if (ptr !== exp_v) begin n_fail++; $display("FAIL reset_ptr: got %h expected %h", ptr, exp_v); end
    @(posedge clk); #1; rst_n = 1'b1;
    step();
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5; addr_a = 4'd3; addr_b = 4'd4;
    sb.push_back(16'h00A5); sb.push_back({8'h00, model[4]});
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({8'h00, data_a} !== exp_v) begin n_fail++; $display("FAIL bypass_a: got %h expected %h", data_a, exp_v); end
    exp_v = sb.pop_front(); n_cmp++;
    if ({8'h00, data_b} !== exp_v) begin n_fail++; $display("FAIL bypass_b_other: got %h expected %h", data_b, exp_v); end
    step();
    wr_en = 1'b0; addr_b = 4'd3;
    sb.push_back(16'h00A5);
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({8'h00, data_b} !== exp_v) begin n_fail++; $display("FAIL read_after_write_b: got %h expected %h", data_b, exp_v); end
    // Both ports bypass the same write at once.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h5C; addr_a = 4'd7; addr_b = 4'd7;
    sb.push_back(16'h005C); sb.push_back(16'h005C);
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({8'h00, data_a} !== exp_v) begin n_fail++; $display("FAIL dual_bypass_a: got %h expected %h", data_a, exp_v); end
    exp_v = sb.pop_front(); n_cmp++;
    if ({8'h00, data_b} !== exp_v) begin n_fail++; $display("FAIL dual_bypass_b: got %h expected %h", data_b, exp_v); end
    step();
    idle();
  endtask

  task automatic test_random_rw();
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom); wr_data = 8'($urandom);
      addr_a = 4'($urandom); addr_b = (i % 5 == 0) ? wr_addr : 4'($urandom);
      sb.push_back({8'h00, (wr_en && wr_addr == addr_a) ? wr_data : model[addr_a]});
      sb.push_back({8'h00, (wr_en && wr_addr == addr_b) ? wr_data : model[addr_b]});
      #1;
      exp_v = sb.pop_front(); n_cmp++;
      if ({8'h00, data_a} !== exp_v) begin n_fail++; $display("FAIL rand_a[%0d] addr %0d: got %h expected %h", i, addr_a, data_a, exp_v); end
      exp_v = sb.pop_front(); n_cmp++;
      if ({8'h00, data_b} !== exp_v) begin n_fail++; $display("FAIL rand_b[%0d] addr %0d: got %h expected %h", i, addr_b, data_b, exp_v); end
      step();
    end
    idle();
  endtask

  task automatic test_flags();
    idle();
    flag_we = 3'b111; c_in = 1'b1; z_in = 1'b0; n_in = 1'b1;
    sb.push_back(16'h0000);
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({13'h0, carry, zero, neg} !== exp_v) begin n_fail++; $display("FAIL flags_no_bypass: got %b%b%b expected %h", carry, zero, neg, exp_v); end
    step();
    sb.push_back(16'h0005);
    flag_we = 3'b010; c_in = 1'b0; z_in = 1'b1; n_in = 1'b0;
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({13'h0, carry, zero, neg} !== exp_v) begin n_fail++; $display("FAIL flags_load_all: got %b%b%b expected %h", carry, zero, neg, exp_v); end
    step();
    sb.push_back(16'h0007);
    flag_we = 3'b100; c_in = 1'b0; z_in = 1'b0; n_in = 1'b0;
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({13'h0, carry, zero, neg} !== exp_v) begin n_fail++; $display("FAIL flags_z_only: got %b%b%b expected %h", carry, zero, neg, exp_v); end
    sb.push_back(16'h0001);
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({15'h0, carry} !== exp_v) begin n_fail++; $display("FAIL carry_held_until_edge: got %b expected %h", carry, exp_v); end
    step();
    sb.push_back(16'h0003);
    flag_we = 3'b001; c_in = 1'b1; z_in = 1'b0; n_in = 1'b0;
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({13'h0, carry, zero, neg} !== exp_v) begin n_fail++; $display("FAIL flags_c_only: got %b%b%b expected %h", carry, zero, neg, exp_v); end
    step();
    idle();
    sb.push_back(16'h0002);
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({13'h0, carry, zero, neg} !== exp_v) begin n_fail++; $display("FAIL flags_n_only: got %b%b%b expected %h", carry, zero, neg, exp_v); end
  endtask

  task automatic test_irq();
    logic [2:0] pat [6];
    logic [2:0] res [6];
    // Each row: action then expected {C,Z,N} after the edge.
    // 0 load 101; 1 enter; 2 load 010; 3 return with flag_we=111/000;
    // 4 load 010; 5 enter+return (swap)
    pat[0] = 3'b101; res[0] = 3'b101;
    pat[1] = 3'b000; res[1] = 3'b101;
    pat[2] = 3'b010; res[2] = 3'b010;
    pat[3] = 3'b000; res[3] = 3'b101;
    pat[4] = 3'b010; res[4] = 3'b010;
    pat[5] = 3'b000; res[5] = 3'b101;
    for (int i = 0; i < 6; i++) begin
      idle();
      {c_in, z_in, n_in} = pat[i];
      flag_we    = (i == 1 || i == 5) ? 3'b000 : 3'b111;
      irq_enter  = (i == 1 || i == 5);
      irq_return = (i == 3 || i == 5);
      sb.push_back({13'h0, res[i]});
      step();
      idle();
      exp_v = sb.pop_front(); n_cmp++;
      if ({13'h0, carry, zero, neg} !== exp_v) begin n_fail++; $display("FAIL irq_step%0d: got %b%b%b expected %h", i, carry, zero, neg, exp_v); end
    end
    // Shadow now holds 010 from the swap; restore it.
    irq_return = 1'b1;
    sb.push_back(16'h0002);
    step();
    idle();
    exp_v = sb.pop_front(); n_cmp++;
    if ({13'h0, carry, zero, neg} !== exp_v) begin n_fail++; $display("FAIL irq_swap_shadow: got %b%b%b expected %h", carry, zero, neg, exp_v); end
    // Entry alongside a flag update: live takes the update, shadow the old value.
    irq_enter = 1'b1; flag_we = 3'b111; {c_in, z_in, n_in} = 3'b111;
    sb.push_back(16'h0007);
    step();
    idle();
    exp_v = sb.pop_front(); n_cmp++;
    if ({13'h0, carry, zero, neg} !== exp_v) begin n_fail++; $display("FAIL irq_enter_with_we: got %b%b%b expected %h", carry, zero, neg, exp_v); end
    irq_return = 1'b1;
    sb.push_back(16'h0002);
    step();
    idle();
    exp_v = sb.pop_front(); n_cmp++;
    if ({13'h0, carry, zero, neg} !== exp_v) begin n_fail++; $display("FAIL irq_enter_with_we_restore: got %b%b%b expected %h", carry, zero, neg, exp_v); end
  endtask

  task automatic test_pointer();
    // op: 0 write, 1 inc, 2 dec, 3 inc+dec, 4 inc+write, 5 dec+write
    int          op   [13];
    logic [3:0]  wa   [13];
    logic [7:0]  wd   [13];
    logic [15:0] pexp [13];
    op[0]  = 0; wa[0]  = 4'd14; wd[0]  = 8'hFF; pexp[0]  = 16'h00FF;
    op[1]  = 0; wa[1]  = 4'd15; wd[1]  = 8'h00; pexp[1]  = 16'h00FF;
    op[2]  = 1; wa[2]  = 4'd0;  wd[2]  = 8'h00; pexp[2]  = 16'h0100;
    op[3]  = 2; wa[3]  = 4'd0;  wd[3]  = 8'h00; pexp[3]  = 16'h00FF;
    op[4]  = 2; wa[4]  = 4'd0;  wd[4]  = 8'h00; pexp[4]  = 16'h00FE;
    op[5]  = 0; wa[5]  = 4'd14; wd[5]  = 8'h00; pexp[5]  = 16'h0000;
    op[6]  = 2; wa[6]  = 4'd0;  wd[6]  = 8'h00; pexp[6]  = 16'hFFFF;
    op[7]  = 1; wa[7]  = 4'd0;  wd[7]  = 8'h00; pexp[7]  = 16'h0000;
    op[8]  = 0; wa[8]  = 4'd15; wd[8]  = 8'h12; pexp[8]  = 16'h1200;
    op[9]  = 0; wa[9]  = 4'd14; wd[9]  = 8'h34; pexp[9]  = 16'h1234;
    op[10] = 3; wa[10] = 4'd0;  wd[10] = 8'h00; pexp[10] = 16'h1234;
    op[11] = 4; wa[11] = 4'd14; wd[11] = 8'h80; pexp[11] = 16'h1280;
    op[12] = 5; wa[12] = 4'd15; wd[12] = 8'hAB; pexp[12] = 16'hAB80;
    for (int i = 0; i < 13; i++) begin
      idle();
      wr_en   = (op[i] == 0 || op[i] == 4 || op[i] == 5);
      wr_addr = wa[i]; wr_data = wd[i];
      ptr_inc = (op[i] == 1 || op[i] == 3 || op[i] == 4);
      ptr_dec = (op[i] == 2 || op[i] == 3 || op[i] == 5);
      sb.push_back(pexp[i]);
      step();
      idle();
      exp_v = sb.pop_front(); n_cmp++;
      if (ptr !== exp_v) begin n_fail++; $display("FAIL ptr_step%0d: got %h expected %h", i, ptr, exp_v); end
    end
    // A write elsewhere does not block stepping; ptr has no bypass pre-edge.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h11; ptr_inc = 1'b1;
    sb.push_back(16'hAB80); sb.push_back(16'hAB81);
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if (ptr !== exp_v) begin n_fail++; $display("FAIL ptr_pre_edge: got %h expected %h", ptr, exp_v); end
    step();
    idle();
    exp_v = sb.pop_front(); n_cmp++;
    if (ptr !== exp_v) begin n_fail++; $display("FAIL ptr_inc_other_write: got %h expected %h", ptr, exp_v); end
  endtask

  task automatic test_mid_reset();
    idle();
    flag_we = 3'b111; {c_in, z_in, n_in} = 3'b111;
    step();
    idle();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h77; addr_a = 4'd3; addr_b = 4'd15;
    #2; rst_n = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    sb.push_back(16'h0000); sb.push_back(16'h0000); sb.push_back(16'h0000); sb.push_back(16'h0000);
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({8'h00, data_a} !== exp_v) begin n_fail++; $display("FAIL midrst_data_a: got %h expected %h", data_a, exp_v); end
    exp_v = sb.pop_front(); n_cmp++;
    if ({8'h00, data_b} !== exp_v) begin n_fail++; $display("FAIL midrst_data_b: got %h expected %h", data_b, exp_v); end
    exp_v = sb.pop_front(); n_cmp++;
    if ({13'h0, carry, zero, neg} !== exp_v) begin n_fail++; $display("FAIL midrst_flags: got %b%b%b expected %h", carry, zero, neg, exp_v); end
    exp_v = sb.pop_front(); n_cmp++;
    if (ptr !== exp_v) begin n_fail++; $display("FAIL midrst_ptr: got %h expected %h", ptr, exp_v); end
    @(posedge clk); #3;
    wr_addr = 4'd5; wr_data = 8'h3C; rst_n = 1'b1;
    step();
    idle();
    addr_a = 4'd5; addr_b = 4'd3;
    sb.push_back(16'h003C); sb.push_back(16'h0000);
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if ({8'h00, data_a} !== exp_v) begin n_fail++; $display("FAIL first_write_after_rst: got %h expected %h", data_a, exp_v); end
    exp_v = sb.pop_front(); n_cmp++;
    if ({8'h00, data_b} !== exp_v) begin n_fail++; $display("FAIL write_lost_in_rst: got %h expected %h", data_b, exp_v); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    rst_n = 1'b1; addr_a = 4'd0; addr_b = 4'd0;
    idle();
    #2 rst_n = 1'b0;
    test_reset();
    test_bypass();
    test_random_rw();
    test_flags();
    test_irq();
    test_pointer();
    test_mid_reset();
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
